// File: rtl/afe_cfg_regfile_pkg.sv
// afe_cfg_regfile_pkg: shared register map, bit positions and reset constants
// for the AFE configuration register file. Optional build macro in the
// design: AFE_CFG_SHADOW_EN (double-buffered start address / size).
package afe_cfg_regfile_pkg;

    // Per-channel register offsets (cfg_addr_i[2:0])
    typedef enum logic [2:0] {
        REG_SADDR    = 3'd0,
        REG_SIZE     = 3'd1,
        REG_CFG      = 3'd2,
        REG_STATUS   = 3'd3,
        REG_CURRADDR = 3'd4,
        REG_BYTELEFT = 3'd5,
        REG_SH_SADDR = 3'd6,
        REG_SH_SIZE  = 3'd7
    } ch_reg_e;

    // Global-space register offsets
    typedef enum logic [2:0] {
        GREG_IRQ_MASK = 3'd0,
        GREG_IRQ_PEND = 3'd1
    } glob_reg_e;

    // Channel/space index of the global register space
    localparam logic [4:0] GLOBAL_SPACE = 5'd30;

    // CFG register bit positions
    localparam int unsigned CFG_CONT_BIT = 0;
    localparam int unsigned CFG_DS_LSB   = 1;
    localparam int unsigned CFG_EN_BIT   = 4;
    localparam int unsigned CFG_CLR_BIT  = 5;
    localparam int unsigned CFG_CHID_LSB = 24;

    // STATUS register bit positions
    localparam int unsigned STATUS_DONE_BIT   = 0;
    localparam int unsigned STATUS_OVF_BIT    = 1;
    localparam int unsigned STATUS_RELOAD_BIT = 2;

    // Datasize after reset (32-bit samples)
    localparam logic [1:0] DATASIZE_RST = 2'b10;

endpackage

// File: rtl/afe_cfg_regfile_ch.sv
// afe_cfg_regfile_ch: configuration, sticky status and (with
// AFE_CFG_SHADOW_EN) shadow start address/size for one L2 channel.
// Produces a combinational readback word for the register selected by
// reg_sel; the top level registers it.
module afe_cfg_regfile_ch
    import afe_cfg_regfile_pkg::*;
#(
    parameter int unsigned AWIDTH     = 12,
    parameter int unsigned TSIZE      = 16,
    parameter int unsigned CHID_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en,
    input  logic [2:0]            reg_sel,
    input  logic [31:0]           wdata,
    input  logic                  busy,
    input  logic                  done,
    input  logic                  ovf,
    input  logic [AWIDTH-1:0]     curr_addr,
    input  logic [TSIZE-1:0]      bytes_left,
    output logic [AWIDTH-1:0]     startaddr,
    output logic [TSIZE-1:0]      size,
    output logic [1:0]            datasize,
    output logic                  continuous,
    output logic [CHID_WIDTH-1:0] chid,
    output logic                  en_pulse,
    output logic                  clr_pulse,
    output logic                  pending,
    output logic [31:0]           rdata
);

    logic wr_saddr;
    logic wr_size;
    logic wr_cfg;
    logic wr_status;
    logic done_st;
    logic ovf_st;
    logic reload_pend;

    // Not every write-data bit lands in a register of this slice
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    assign wr_saddr  = wr_en && (reg_sel == REG_SADDR);
    assign wr_size   = wr_en && (reg_sel == REG_SIZE);
    assign wr_cfg    = wr_en && (reg_sel == REG_CFG);
    assign wr_status = wr_en && (reg_sel == REG_STATUS);

`ifdef AFE_CFG_SHADOW_EN
    logic [AWIDTH-1:0] sh_saddr;
    logic [TSIZE-1:0]  sh_size;
    logic              wr_shadow;
    logic              reload;

    assign wr_shadow = wr_en && ((reg_sel == REG_SH_SADDR) || (reg_sel == REG_SH_SIZE));
    // Old shadow contents are applied; a coinciding shadow write re-arms below
    assign reload    = done && continuous && reload_pend;

    // Shadow storage and reload bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_saddr    <= '0;
            sh_size     <= '0;
            reload_pend <= 1'b0;
        end else begin
            // Shadow values are aligned like the active ones they replace
            if (wr_en && (reg_sel == REG_SH_SADDR)) sh_saddr <= {wdata[AWIDTH-1:2], 2'b00};
            if (wr_en && (reg_sel == REG_SH_SIZE))  sh_size  <= {wdata[TSIZE-1:2], 2'b00};
            if (wr_shadow)   reload_pend <= 1'b1;
            else if (reload) reload_pend <= 1'b0;
        end
    end
`else
    assign reload_pend = 1'b0;
`endif

    // Active start address and size: shadow reload, then direct bus writes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            startaddr <= '0;
            size      <= '0;
        end else begin
`ifdef AFE_CFG_SHADOW_EN
            if (reload) begin
                startaddr <= sh_saddr;
                size      <= sh_size;
            end
`endif
            // NOTE: with non-blocking assignments the last one executed in the
            // block wins, so a direct bus write overrides a coinciding reload.
            if (wr_saddr) startaddr <= {wdata[AWIDTH-1:2], 2'b00};
            if (wr_size)  size      <= {wdata[TSIZE-1:2], 2'b00};
        end
    end

    // Static transfer configuration fields from CFG
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            continuous <= 1'b0;
            datasize   <= DATASIZE_RST;
            chid       <= '0;
        end else if (wr_cfg) begin
            continuous <= wdata[CFG_CONT_BIT];
            datasize   <= wdata[CFG_DS_LSB +: 2];
            chid       <= wdata[CFG_CHID_LSB +: CHID_WIDTH];
        end
    end

    // Enable/clear strobes: high for the single cycle after a CFG write
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_pulse  <= 1'b0;
            clr_pulse <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of block order.
            en_pulse  <= wr_cfg && wdata[CFG_EN_BIT];
            clr_pulse <= wr_cfg && wdata[CFG_CLR_BIT];
        end
    end

    // Sticky event status: set by the event pulse, write-1-to-clear, set wins
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_st <= 1'b0;
            ovf_st  <= 1'b0;
        end else begin
            done_st <= done | (done_st & ~(wr_status & wdata[STATUS_DONE_BIT]));
            ovf_st  <= ovf  | (ovf_st  & ~(wr_status & wdata[STATUS_OVF_BIT]));
        end
    end

    assign pending = done_st | ovf_st | reload_pend;

    // Readback word for the selected register
    always_comb begin
        // NOTE: default every output first so no path through the case
        // leaves it unassigned and infers a latch.
        rdata = '0;
        case (reg_sel)
            REG_SADDR: rdata = 32'(startaddr);
            REG_SIZE:  rdata = 32'(size);
            REG_CFG: begin
                rdata[CFG_CONT_BIT]                 = continuous;
                rdata[CFG_DS_LSB +: 2]              = datasize;
                rdata[CFG_EN_BIT]                   = busy;
                rdata[CFG_CHID_LSB +: CHID_WIDTH]   = chid;
            end
            REG_STATUS: begin
                rdata[STATUS_DONE_BIT]   = done_st;
                rdata[STATUS_OVF_BIT]    = ovf_st;
                rdata[STATUS_RELOAD_BIT] = reload_pend;
            end
            REG_CURRADDR: rdata = 32'(curr_addr);
            REG_BYTELEFT: rdata = 32'(bytes_left);
`ifdef AFE_CFG_SHADOW_EN
            REG_SH_SADDR: rdata = 32'(sh_saddr);
            REG_SH_SIZE:  rdata = 32'(sh_size);
`endif
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/afe_cfg_regfile.sv
// afe_cfg_regfile: config-bus register file for the AFE L2 channels.
// Decodes the bus address, instantiates one afe_cfg_regfile_ch slice per
// channel, holds the global IRQ mask, the registered read port and irq_o.
// Optional build macro: AFE_CFG_SHADOW_EN (shadow start address / size).
module afe_cfg_regfile
    import afe_cfg_regfile_pkg::*;
#(
    parameter int unsigned L2_NUM_CHS     = 8,
    parameter int unsigned L2_AWIDTH_NOAL = 12,
    parameter int unsigned L2_TRANS_SIZE  = 16,
    parameter int unsigned AFE_CHID_WIDTH = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [31:0]                            cfg_wdata_i,
    input  logic [10:0]                            cfg_addr_i,
    input  logic                                   cfg_valid_i,
    input  logic                                   cfg_rwn_i,
    output logic                                   cfg_ready_o,
    output logic [31:0]                            cfg_rdata_o,
    output logic                                   cfg_rvalid_o,
    output logic [L2_NUM_CHS*L2_AWIDTH_NOAL-1:0]   cfg_l2_startaddr_o,
    output logic [L2_NUM_CHS*L2_TRANS_SIZE-1:0]    cfg_l2_size_o,
    output logic [L2_NUM_CHS*2-1:0]                cfg_l2_datasize_o,
    output logic [L2_NUM_CHS-1:0]                  cfg_l2_continuous_o,
    output logic [L2_NUM_CHS*AFE_CHID_WIDTH-1:0]   cfg_l2_chid_o,
    output logic [L2_NUM_CHS-1:0]                  cfg_l2_en_o,
    output logic [L2_NUM_CHS-1:0]                  cfg_l2_clr_o,
    input  logic [L2_NUM_CHS-1:0]                  cfg_l2_en_i,
    input  logic [L2_NUM_CHS-1:0]                  cfg_l2_done_i,
    input  logic [L2_NUM_CHS-1:0]                  cfg_l2_ovf_i,
    input  logic [L2_NUM_CHS*L2_AWIDTH_NOAL-1:0]   cfg_l2_curr_addr_i,
    input  logic [L2_NUM_CHS*L2_TRANS_SIZE-1:0]    cfg_l2_bytes_left_i,
    output logic                                   irq_o
);

    logic [4:0]            sel_space;
    logic [2:0]            sel_reg;
    logic                  wr_req;
    logic                  rd_req;
    logic [31:0]           ch_rdata [L2_NUM_CHS];
    logic [L2_NUM_CHS-1:0] ch_pending;
    logic [L2_NUM_CHS-1:0] irq_mask;
    logic [31:0]           rd_word;

    // Address bits above the channel field are not decoded
    logic unused_addr_hi;
    assign unused_addr_hi = ^cfg_addr_i[10:8];

    assign cfg_ready_o = 1'b1;
    assign sel_space   = cfg_addr_i[7:3];
    assign sel_reg     = cfg_addr_i[2:0];
    assign wr_req      = cfg_valid_i && !cfg_rwn_i;
    assign rd_req      = cfg_valid_i &&  cfg_rwn_i;

    for (genvar c = 0; c < L2_NUM_CHS; c++) begin : g_ch
        afe_cfg_regfile_ch #(
            .AWIDTH     (L2_AWIDTH_NOAL),
            .TSIZE      (L2_TRANS_SIZE),
            .CHID_WIDTH (AFE_CHID_WIDTH)
        ) u_ch (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .wr_en      (wr_req && (sel_space == 5'(c))),
            .reg_sel    (sel_reg),
            .wdata      (cfg_wdata_i),
            .busy       (cfg_l2_en_i[c]),
            .done       (cfg_l2_done_i[c]),
            .ovf        (cfg_l2_ovf_i[c]),
            .curr_addr  (cfg_l2_curr_addr_i[c*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL]),
            .bytes_left (cfg_l2_bytes_left_i[c*L2_TRANS_SIZE +: L2_TRANS_SIZE]),
            .startaddr  (cfg_l2_startaddr_o[c*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL]),
            .size       (cfg_l2_size_o[c*L2_TRANS_SIZE +: L2_TRANS_SIZE]),
            .datasize   (cfg_l2_datasize_o[c*2 +: 2]),
            .continuous (cfg_l2_continuous_o[c]),
            .chid       (cfg_l2_chid_o[c*AFE_CHID_WIDTH +: AFE_CHID_WIDTH]),
            .en_pulse   (cfg_l2_en_o[c]),
            .clr_pulse  (cfg_l2_clr_o[c]),
            .pending    (ch_pending[c]),
            .rdata      (ch_rdata[c])
        );
    end

    // Global IRQ mask register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_mask <= '0;
        end else if (wr_req && (sel_space == GLOBAL_SPACE) && (sel_reg == GREG_IRQ_MASK)) begin
            irq_mask <= cfg_wdata_i[L2_NUM_CHS-1:0];
        end
    end

    // Registered interrupt: any pending channel that is unmasked
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) irq_o <= 1'b0;
        else         irq_o <= |(ch_pending & irq_mask);
    end

    // Read mux across channel slices and the global space; unmapped reads 0
    always_comb begin
        rd_word = '0;
        if (sel_space == GLOBAL_SPACE) begin
            case (sel_reg)
                GREG_IRQ_MASK: rd_word = 32'(irq_mask);
                GREG_IRQ_PEND: rd_word = 32'(ch_pending);
                default:       rd_word = '0;
            endcase
        end else begin
            for (int c = 0; c < L2_NUM_CHS; c++) begin
                if (sel_space == 5'(c)) rd_word = ch_rdata[c];
            end
        end
    end

    // Read data register: captured on an accepted read, held otherwise
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_rdata_o  <= '0;
            cfg_rvalid_o <= 1'b0;
        end else begin
            cfg_rvalid_o <= rd_req;
            if (rd_req) cfg_rdata_o <= rd_word;
        end
    end

endmodule

// File: tb/tb_afe_cfg_regfile.sv
// tb_afe_cfg_regfile: directed scenarios followed by randomized bus traffic
// and channel events, all outputs compared every cycle against a
// behavioural model of the register file. Honors AFE_CFG_SHADOW_EN.
module tb_afe_cfg_regfile;

    localparam int NCH = 8;
    localparam int AW  = 12;
    localparam int TS  = 16;
    localparam int CHW = 4;
`ifdef AFE_CFG_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_ni;
    logic [31:0]        wdata;
    logic [10:0]        addr;
    logic               valid, rwn;
    logic               ready;
    logic [31:0]        rdata;
    logic               rvalid;
    logic [NCH*AW-1:0]  startaddr;
    logic [NCH*TS-1:0]  size;
    logic [NCH*2-1:0]   datasize;
    logic [NCH-1:0]     continuous;
    logic [NCH*CHW-1:0] chid;
    logic [NCH-1:0]     en_o, clr_o;
    logic [NCH-1:0]     l2_en, done, ovf;
    logic [NCH*AW-1:0]  curr_addr;
    logic [NCH*TS-1:0]  bytes_left;
    logic               irq;

    afe_cfg_regfile #(
        .L2_NUM_CHS(NCH), .L2_AWIDTH_NOAL(AW), .L2_TRANS_SIZE(TS), .AFE_CHID_WIDTH(CHW)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_ni),
        .cfg_wdata_i         (wdata),
        .cfg_addr_i          (addr),
        .cfg_valid_i         (valid),
        .cfg_rwn_i           (rwn),
        .cfg_ready_o         (ready),
        .cfg_rdata_o         (rdata),
        .cfg_rvalid_o        (rvalid),
        .cfg_l2_startaddr_o  (startaddr),
        .cfg_l2_size_o       (size),
        .cfg_l2_datasize_o   (datasize),
        .cfg_l2_continuous_o (continuous),
        .cfg_l2_chid_o       (chid),
        .cfg_l2_en_o         (en_o),
        .cfg_l2_clr_o        (clr_o),
        .cfg_l2_en_i         (l2_en),
        .cfg_l2_done_i       (done),
        .cfg_l2_ovf_i        (ovf),
        .cfg_l2_curr_addr_i  (curr_addr),
        .cfg_l2_bytes_left_i (bytes_left),
        .irq_o               (irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [AW-1:0]  m_saddr    [NCH];
    logic [TS-1:0]  m_size     [NCH];
    logic [AW-1:0]  m_sh_saddr [NCH];
    logic [TS-1:0]  m_sh_size  [NCH];
    logic [1:0]     m_ds       [NCH];
    logic [CHW-1:0] m_chid     [NCH];
    logic [NCH-1:0] m_cont, m_done, m_ovf, m_rl, m_mask, m_en, m_clr;
    logic [31:0]    m_rdata;
    logic           m_rvalid, m_irq;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_saddr[c] = '0; m_size[c] = '0; m_sh_saddr[c] = '0; m_sh_size[c] = '0;
            m_ds[c] = 2'b10; m_chid[c] = '0;
        end
        m_cont = '0; m_done = '0; m_ovf = '0; m_rl = '0; m_mask = '0;
        m_en = '0; m_clr = '0; m_rdata = '0; m_rvalid = 1'b0; m_irq = 1'b0;
    endtask

    function automatic logic [NCH-1:0] model_pending();
        return m_done | m_ovf | m_rl;
    endfunction

    function automatic logic [31:0] model_read(input int ch, input int r);
        logic [31:0] v = '0;
        if (ch < NCH) begin
            case (r)
                0: v = 32'(m_saddr[ch]);
                1: v = 32'(m_size[ch]);
                2: v = (32'(m_chid[ch]) << 24) | (32'(l2_en[ch]) << 4)
                       | (32'(m_ds[ch]) << 1) | 32'(m_cont[ch]);
                3: v = (32'(m_rl[ch]) << 2) | (32'(m_ovf[ch]) << 1) | 32'(m_done[ch]);
                4: v = 32'(curr_addr[ch*AW +: AW]);
                5: v = 32'(bytes_left[ch*TS +: TS]);
                6: v = SHADOW ? 32'(m_sh_saddr[ch]) : 32'h0;
                7: v = SHADOW ? 32'(m_sh_size[ch])  : 32'h0;
                default: v = '0;
            endcase
        end else if (ch == 30) begin
            if (r == 0) v = 32'(m_mask);
            if (r == 1) v = 32'(model_pending());
        end
        return v;
    endfunction

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        int ch, r;
        ch = int'(addr[7:3]);
        r  = int'(addr[2:0]);
        m_irq    = |(model_pending() & m_mask);
        m_rvalid = valid && rwn;
        if (valid && rwn) m_rdata = model_read(ch, r);
        m_en  = '0;
        m_clr = '0;
        for (int c = 0; c < NCH; c++) begin
            bit wr, fire;
            wr   = valid && !rwn && (ch == c);
            fire = SHADOW && done[c] && m_cont[c] && m_rl[c];
            m_done[c] = done[c] | (m_done[c] & !(wr && r == 3 && wdata[0]));
            m_ovf[c]  = ovf[c]  | (m_ovf[c]  & !(wr && r == 3 && wdata[1]));
            if (fire) begin
                m_saddr[c] = m_sh_saddr[c];
                m_size[c]  = m_sh_size[c];
                m_rl[c]    = 1'b0;
            end
            if (wr) begin
                case (r)
                    0: m_saddr[c] = wdata[AW-1:0] & ~AW'(3);
                    1: m_size[c]  = wdata[TS-1:0] & ~TS'(3);
                    2: begin
                        m_cont[c] = wdata[0];
                        m_ds[c]   = wdata[2:1];
                        m_chid[c] = wdata[24 +: CHW];
                        m_en[c]   = wdata[4];
                        m_clr[c]  = wdata[5];
                    end
                    6: if (SHADOW) begin m_sh_saddr[c] = wdata[AW-1:0] & ~AW'(3); m_rl[c] = 1'b1; end
                    7: if (SHADOW) begin m_sh_size[c]  = wdata[TS-1:0] & ~TS'(3); m_rl[c] = 1'b1; end
                    default: ;
                endcase
            end
        end
        if (valid && !rwn && ch == 30 && r == 0) m_mask = wdata[NCH-1:0];
    endtask

    task automatic check_all(input string ph);
        logic [NCH*AW-1:0]  e_sa;
        logic [NCH*TS-1:0]  e_sz;
        logic [NCH*2-1:0]   e_ds;
        logic [NCH*CHW-1:0] e_id;
        for (int c = 0; c < NCH; c++) begin
            e_sa[c*AW +: AW]   = m_saddr[c];
            e_sz[c*TS +: TS]   = m_size[c];
            e_ds[c*2 +: 2]     = m_ds[c];
            e_id[c*CHW +: CHW] = m_chid[c];
        end
        check({ph, ".ready"},      128'(ready),      128'(1'b1));
        check({ph, ".startaddr"},  128'(startaddr),  128'(e_sa));
        check({ph, ".size"},       128'(size),       128'(e_sz));
        check({ph, ".datasize"},   128'(datasize),   128'(e_ds));
        check({ph, ".continuous"}, 128'(continuous), 128'(m_cont));
        check({ph, ".chid"},       128'(chid),       128'(e_id));
        check({ph, ".en"},         128'(en_o),       128'(m_en));
        check({ph, ".clr"},        128'(clr_o),      128'(m_clr));
        check({ph, ".rdata"},      128'(rdata),      128'(m_rdata));
        check({ph, ".rvalid"},     128'(rvalid),     128'(m_rvalid));
        check({ph, ".irq"},        128'(irq),        128'(m_irq));
    endtask

    // One clock: model advance, edge, sample 1 time unit later, drop pulses
    task automatic tick(input string ph);
        model_step();
        @(posedge clk);
        #1;
        check_all(ph);
        valid = 1'b0;
        done  = '0;
        ovf   = '0;
    endtask

    function automatic logic [10:0] mk_addr(input int ch, input int r);
        return {3'b000, 5'(ch), 3'(r)};
    endfunction

    task automatic bus_wr(input int ch, input int r, input logic [31:0] d);
        valid = 1'b1; rwn = 1'b0; addr = mk_addr(ch, r); wdata = d;
    endtask

    task automatic bus_rd(input int ch, input int r);
        valid = 1'b1; rwn = 1'b1; addr = mk_addr(ch, r); wdata = $urandom;
    endtask

    initial begin
        rst_ni = 1'b0;
        valid = 1'b0; rwn = 1'b0; addr = '0; wdata = '0;
        l2_en = '0; done = '0; ovf = '0; curr_addr = '0; bytes_left = '0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_ni = 1'b1;

        // CFG read after reset shows datasize reset value
        bus_rd(0, 2); tick("cfg_rd");
        check("rst_cfg_rdata", 128'(rdata), 128'(32'h4));
        check("rst_cfg_rvalid", 128'(rvalid), 128'(1'b1));
        tick("idle0");
        check("rdata_hold", 128'(rdata), 128'(32'h4));
        check("rvalid_drop", 128'(rvalid), 128'(1'b0));

        // Aligned SADDR write and readback
        bus_wr(2, 0, 32'h123); tick("sa_wr");
        check("sa2_aligned", 128'(startaddr[2*AW +: AW]), 128'(12'h120));
        bus_rd(2, 0); tick("sa_rd");
        check("sa2_readback", 128'(rdata), 128'(32'h120));

        // en/clr one-cycle strobes
        bus_wr(1, 2, 32'h30); tick("encl");
        check("en1_hi",  128'(en_o[1]),  128'(1'b1));
        check("clr1_hi", 128'(clr_o[1]), 128'(1'b1));
        tick("encl_idle");
        check("en1_lo",  128'(en_o[1]),  128'(1'b0));
        check("clr1_lo", 128'(clr_o[1]), 128'(1'b0));

        // Sticky done, masked irq, set beats W1C
        bus_wr(30, 0, 32'h8); tick("mask");
        done[3] = 1'b1; tick("done3");
        bus_rd(3, 3); tick("st3_rd");
        check("st3_set", 128'(rdata), 128'(32'h1));
        check("irq_set", 128'(irq), 128'(1'b1));
        bus_wr(3, 3, 32'h1); done[3] = 1'b1; tick("w1c_vs_set");
        bus_rd(3, 3); tick("st3_rd2");
        check("st3_set_wins", 128'(rdata), 128'(32'h1));
        bus_wr(3, 3, 32'h1); tick("w1c");
        tick("w1c_idle");
        tick("w1c_idle2");
        check("irq_cleared", 128'(irq), 128'(1'b0));

`ifdef AFE_CFG_SHADOW_EN
        // Shadow reload on done in continuous mode
        bus_wr(0, 2, 32'h1); tick("sh_cfg");
        bus_wr(0, 6, 32'h400); tick("sh_wr");
        bus_rd(0, 3); tick("sh_st_rd");
        check("reload_pend_set", 128'(rdata), 128'(32'h4));
        done[0] = 1'b1; tick("sh_done");
        check("sh_reload_sa", 128'(startaddr[0 +: AW]), 128'(12'h400));
        bus_rd(0, 3); tick("sh_st_rd2");
        check("reload_pend_clr", 128'(rdata), 128'(32'h1));
`endif

        // Unimplemented channel: write ignored, read returns 0 with rvalid
        bus_wr(29, 0, 32'hFFFF_FFFF); tick("ch29_wr");
        bus_rd(29, 0); tick("ch29_rd");
        check("ch29_rdata", 128'(rdata), 128'(32'h0));
        check("ch29_rvalid", 128'(rvalid), 128'(1'b1));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int sel, ch;
            sel = $urandom_range(0, 9);
            if (sel < 8)       ch = sel;
            else if (sel == 8) ch = 30;
            else begin
                int k;
                k  = $urandom_range(0, 22);
                ch = (k < 22) ? 8 + k : 31;
            end
            valid      = ($urandom_range(0, 9) < 7);
            rwn        = $urandom_range(0, 1) == 1;
            addr       = {3'($urandom), 5'(ch), 3'($urandom)};
            wdata      = $urandom;
            l2_en      = NCH'($urandom);
            done       = NCH'($urandom & $urandom & $urandom);
            ovf        = NCH'($urandom & $urandom & $urandom);
            curr_addr  = {$urandom, $urandom, $urandom};
            bytes_left = {$urandom, $urandom, $urandom, $urandom};
            tick("rnd");
        end

        // Reset right after a read returns: rvalid and state drop at once
        bus_rd(0, 2); tick("pre_rst_rd");
        #2;
        rst_ni = 1'b0;
        model_reset();
        #1;
        check_all("mid_rst");
        check("mid_rst_rvalid", 128'(rvalid), 128'(1'b0));
        @(negedge clk);
        rst_ni = 1'b1;
        tick("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
